memory_access_unit: RTL and testbench
=====================================

# memory_access_unit

Memory-access (MA) stage of the SimpleRISC pipeline, directly downstream of the ALU block. It takes the ALU result and the store operand for one instruction at a time. For `ld`/`st` it runs a request/acknowledge transaction with data memory using the ALU result as the address; for all other instructions it passes the ALU result through. It then presents a registered result, destination register and write-back enable to the register-write stage.

## Interface
Parameters:
- `WAIT_MAX`, default 255: maximum cycles `mem_req` stays high without `mem_ack` before the access aborts.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `ex_valid`  in  1  EX stage presents a valid instruction
- `ex_ready`  out  1  MA can accept an instruction this cycle
- `aluResult`  in  32  ALU output; data-memory byte address for ld/st
- `op2`  in  32  store data
- `isLd`, `isSt`  in  1 each  instruction is a load / store
- `isWb`  in  1  instruction writes a register
- `rd`  in  4  destination register
- `mem_req`  out  1  memory request
- `mem_we`  out  1  request is a write
- `mem_addr`  out  32  request address
- `mem_wdata`  out  32  write data
- `mem_ack`  in  1  memory completes the request
- `mem_rdata`  in  32  load data, valid with `mem_ack`
- `ma_valid`  out  1  one-cycle pulse: MA outputs are valid
- `ma_result`  out  32  load data or pass-through ALU result
- `ma_rd`  out  4  destination register
- `ma_isWb`  out  1  register write enable for the RW stage
- `ma_err`  out  1  misaligned address, illegal ld+st combination, or timeout

## Operation
- Acceptance: an instruction is accepted when `ex_valid & ex_ready`. `ex_ready` = 1 only in IDLE.
- States: IDLE and BUSY.
- IDLE, accepted instruction with `isLd = isSt = 0`:
  - next cycle `ma_valid`=1, `ma_result`=`aluResult`, `ma_rd`=`rd`, `ma_isWb`=`isWb`, `ma_err`=0.
  - State stays IDLE.
- IDLE, accepted ld/st with `aluResult[1:0] != 0`, or with `isLd & isSt`:
  - no memory request is issued;
  - next cycle `ma_valid`=1, `ma_err`=1, `ma_isWb`=0.
- IDLE, accepted aligned ld/st:
  - latch address, store data, `rd`, `isWb` and the ld/st type;
  - go to BUSY and clear the wait counter.
- BUSY:
  - `mem_req`=1; `mem_we`=`isSt`; `mem_addr`/`mem_wdata` hold the latched values, stable until ack;
  - the wait counter increments each cycle that `mem_ack` is 0.
- BUSY with `mem_ack`=1, next cycle:
  - `mem_req`=0, state IDLE, `ma_valid`=1, `ma_err`=0;
  - ld: `ma_result`=`mem_rdata` captured on the ack cycle, `ma_isWb`=latched `isWb`;
  - st: `ma_result`=latched address, `ma_isWb`=0.
- BUSY with counter = `WAIT_MAX` and no ack, next cycle:
  - abort: `mem_req`=0, state IDLE;
  - `ma_valid`=1, `ma_err`=1, `ma_isWb`=0.
- Ack priority: if `mem_ack` arrives in the same cycle the counter reaches `WAIT_MAX`, the ack wins and the access completes normally.
- `mem_ack` in IDLE is ignored.
- `ma_result`, `ma_rd`, `ma_isWb`, `ma_err` hold their values between `ma_valid` pulses.

## Timing
- Reset values: state IDLE, `ex_ready`=1, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `ma_valid`=0, `ma_result`=0, `ma_rd`=0, `ma_isWb`=0, `ma_err`=0, counter 0.
- Non-memory and rejected instructions: 1-cycle latency. Back-to-back acceptance every cycle is allowed.
- Memory access (accept at cycle 0):
  - `mem_req` high from cycle 1;
  - ack sampled at cycle k ≥ 1;
  - `ma_valid` at cycle k+1;
  - next accept at cycle k+1.
  - Zero-wait memory (ack at cycle 1) gives 2-cycle latency.
- Timeout: `mem_req` is high for exactly `WAIT_MAX`+1 cycles, then `ma_valid`/`ma_err` follow in the next cycle.
- Reset asserted mid-access: `mem_req` and `ma_valid` drop immediately (asynchronously). No result is produced for the in-flight instruction.
- `ex_ready` is registered state; it never depends combinationally on `ex_valid`.

## Structure
- Shared package `simplerisc_pkg` holds:
  - `ma_state_t` enum {`MA_IDLE`, `MA_BUSY`};
  - `WORD_W`=32 and `REG_W`=4;
  - localparam `ADDR_ALIGN_MASK`=2'b11.
- One natural sub-module: `ma_wait_counter`. It is a saturating counter with clear/enable inputs and a `hit` output when the count equals `WAIT_MAX`.
- All other logic is the FSM and output registers in the top module.

## Test plan
- **ALU pass-through.** Accept `isLd`=`isSt`=0, `aluResult`=0x0000_1234, `rd`=5, `isWb`=1 → next cycle `ma_valid`=1, `ma_result`=0x1234, `ma_rd`=5, `ma_isWb`=1, `mem_req` never high.
- **Load with wait states.** Load, addr 0x100, `rd`=3; ack after 3 cycles of req with `mem_rdata`=0xDEAD_BEEF → `mem_req` high for 3 cycles with `mem_we`=0; `ma_valid` the cycle after ack; `ma_result`=0xDEADBEEF, `ma_isWb`=1; `ex_ready`=0 throughout.
- **Zero-wait store.** Store, addr 0x200, `op2`=0xA5A5_A5A5, ack in the first req cycle → `mem_we`=1, `mem_wdata`=0xA5A5A5A5; `ma_valid` at cycle 2 with `ma_isWb`=0, `ma_err`=0.
- **Misaligned access.** Load at addr 0x102 → no `mem_req`; next cycle `ma_valid`=1, `ma_err`=1, `ma_isWb`=0.
- **Timeout.** `WAIT_MAX`=4 and memory never acks → `mem_req` high 5 cycles, then `ma_err`=1. A repeat where ack arrives on the 5th req cycle completes normally with `ma_err`=0.
- **Reset mid-access.** Assert `rst` during BUSY → `mem_req`=0 immediately; after release `ex_ready`=1 and no `ma_valid` pulse appears for the aborted load.

Source files
------------

// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC types and constants used by the memory-access stage.
package simplerisc_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 4;
  localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

  typedef enum logic {
    MA_IDLE = 1'b0,
    MA_BUSY = 1'b1
  } ma_state_t;

  // Word accesses must sit on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] & ADDR_ALIGN_MASK) != 2'b00;
  endfunction
endpackage

// File: rtl/memory_access_unit_if.sv
// EX-side handshake, data-memory bus and RW-side result bundle of the MA stage.
interface memory_access_unit_if;
  import simplerisc_pkg::*;

  logic              ex_valid;
  logic              ex_ready;
  logic [WORD_W-1:0] aluResult;
  logic [WORD_W-1:0] op2;
  logic              isLd;
  logic              isSt;
  logic              isWb;
  logic [REG_W-1:0]  rd;
  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;
  logic              ma_valid;
  logic [WORD_W-1:0] ma_result;
  logic [REG_W-1:0]  ma_rd;
  logic              ma_isWb;
  logic              ma_err;

  // The MA stage itself.
  modport master (
    input  ex_valid, aluResult, op2, isLd, isSt, isWb, rd, mem_ack, mem_rdata,
    output ex_ready, mem_req, mem_we, mem_addr, mem_wdata,
           ma_valid, ma_result, ma_rd, ma_isWb, ma_err
  );

  // The surrounding pipeline and data memory.
  modport slave (
    output ex_valid, aluResult, op2, isLd, isSt, isWb, rd, mem_ack, mem_rdata,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata,
           ma_valid, ma_result, ma_rd, ma_isWb, ma_err
  );
endinterface

// File: rtl/ma_wait_counter.sv
// Saturating wait-state counter; o_hit flags that the count reached WAIT_MAX.
module ma_wait_counter #(
  parameter int WAIT_MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);
  localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_hit = (r_cnt == CNT_W'(WAIT_MAX));

  // Clear wins over enable; the count never moves past WAIT_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_cnt <= '0;
    else if (i_clr)          r_cnt <= '0;
    else if (i_en && !o_hit) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/memory_access_unit.sv
// SimpleRISC memory-access stage: ld/st memory handshake or ALU pass-through,
// presenting a registered one-cycle result pulse to the register-write stage.
module memory_access_unit
  import simplerisc_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  memory_access_unit_if.master bus
);
  ma_state_t         r_state, w_state_nxt;
  logic [WORD_W-1:0] r_addr, r_wdata;
  logic [REG_W-1:0]  r_rd;
  logic              r_isWb, r_isSt;

  logic              r_ma_valid, r_ma_isWb, r_ma_err;
  logic [WORD_W-1:0] r_ma_result;
  logic [REG_W-1:0]  r_ma_rd;

  logic              w_latch, w_cnt_clr, w_cnt_en, w_hit;
  logic              w_out_vld, w_out_isWb, w_out_err;
  logic [WORD_W-1:0] w_out_result;
  logic [REG_W-1:0]  w_out_rd;
  logic              w_is_mem, w_bad;

  ma_wait_counter #(.WAIT_MAX(WAIT_MAX)) u_wait (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_hit (w_hit)
  );

  assign w_is_mem = bus.isLd | bus.isSt;
  assign w_bad    = w_is_mem & (is_misaligned(bus.aluResult) | (bus.isLd & bus.isSt));

  // State register; reset lands in IDLE so mem_req drops asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MA_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus the result to present next cycle; outputs hold by default.
  always_comb begin
    w_state_nxt  = r_state;
    w_latch      = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_en     = 1'b0;
    w_out_vld    = 1'b0;
    w_out_result = r_ma_result;
    w_out_rd     = r_ma_rd;
    w_out_isWb   = r_ma_isWb;
    w_out_err    = r_ma_err;
    case (r_state)
      MA_IDLE: begin
        if (bus.ex_valid) begin
          if (!w_is_mem || w_bad) begin
            // Pass-through and rejected accesses both answer in one cycle.
            w_out_vld    = 1'b1;
            w_out_result = bus.aluResult;
            w_out_rd     = bus.rd;
            w_out_isWb   = w_bad ? 1'b0 : bus.isWb;
            w_out_err    = w_bad;
          end else begin
            w_latch     = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = MA_BUSY;
          end
        end
      end
      MA_BUSY: begin
        if (bus.mem_ack) begin
          // Ack is checked first so it beats a simultaneous timeout.
          w_state_nxt  = MA_IDLE;
          w_out_vld    = 1'b1;
          w_out_result = r_isSt ? r_addr : bus.mem_rdata;
          w_out_rd     = r_rd;
          w_out_isWb   = r_isSt ? 1'b0 : r_isWb;
          w_out_err    = 1'b0;
        end else if (w_hit) begin
          w_state_nxt = MA_IDLE;
          w_out_vld   = 1'b1;
          w_out_rd    = r_rd;
          w_out_isWb  = 1'b0;
          w_out_err   = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      default: w_state_nxt = MA_IDLE;
    endcase
  end

  // Capture the access operands on acceptance; they stay stable through BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_isWb  <= 1'b0;
      r_isSt  <= 1'b0;
    end else if (w_latch) begin
      r_addr  <= bus.aluResult;
      r_wdata <= bus.op2;
      r_rd    <= bus.rd;
      r_isWb  <= bus.isWb;
      r_isSt  <= bus.isSt;
    end
  end

  // Registered result bundle toward the RW stage; valid is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ma_valid  <= 1'b0;
      r_ma_result <= '0;
      r_ma_rd     <= '0;
      r_ma_isWb   <= 1'b0;
      r_ma_err    <= 1'b0;
    end else begin
      r_ma_valid  <= w_out_vld;
      r_ma_result <= w_out_result;
      r_ma_rd     <= w_out_rd;
      r_ma_isWb   <= w_out_isWb;
      r_ma_err    <= w_out_err;
    end
  end

  assign bus.ex_ready  = (r_state == MA_IDLE);
  assign bus.mem_req   = (r_state == MA_BUSY);
  assign bus.mem_we    = (r_state == MA_BUSY) & r_isSt;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.ma_valid  = r_ma_valid;
  assign bus.ma_result = r_ma_result;
  assign bus.ma_rd     = r_ma_rd;
  assign bus.ma_isWb   = r_ma_isWb;
  assign bus.ma_err    = r_ma_err;
endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit: directed plan cases plus random mix.
module tb_memory_access_unit;
  localparam int WMAX = 4;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  rd;
    logic        isWb;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  memory_access_unit_if bus();

  memory_access_unit #(.WAIT_MAX(WMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: every ma_valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.ma_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ma_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ma_err", 32'(bus.ma_err), 32'(e.err));
        chk("ma_isWb", 32'(bus.ma_isWb), 32'(e.isWb));
        if (!e.err) begin
          chk("ma_result", bus.ma_result, e.result);
          chk("ma_rd", 32'(bus.ma_rd), 32'(e.rd));
        end
      end
    end
  end

  // Issue one instruction at a negedge; d = req cycle on which memory acks.
  // Returns at a negedge with the unit idle again.
  task automatic issue(input logic ld, input logic st, input logic wb,
                       input logic [31:0] alu, input logic [31:0] o2,
                       input logic [3:0] r, input int d);
    exp_t        e;
    int          reqs;
    int          want_reqs;
    logic [31:0] rdat;
    logic        mem, rej;
    rdat = $urandom;
    mem  = ld | st;
    rej  = mem && ((alu % 4) != 0 || (ld && st));
    chk("ex_ready_idle", 32'(bus.ex_ready), 32'd1);
    chk("mem_req_idle", 32'(bus.mem_req), 32'd0);
    bus.ex_valid = 1'b1; bus.aluResult = alu; bus.op2 = o2;
    bus.isLd = ld; bus.isSt = st; bus.isWb = wb; bus.rd = r;
    if (!mem)              e = '{alu, r, wb, 1'b0};
    else if (rej)          e = '{32'd0, r, 1'b0, 1'b1};
    else if (d > WMAX + 1) e = '{32'd0, r, 1'b0, 1'b1};
    else if (st)           e = '{alu, r, 1'b0, 1'b0};
    else                   e = '{rdat, r, wb, 1'b0};
    exp_q.push_back(e);
    @(posedge clk);
    if (mem && !rej) begin
      want_reqs = (d > WMAX + 1) ? WMAX + 1 : d;
      reqs = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        bus.ex_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        if (!bus.mem_req) break;
        reqs++;
        chk("ex_ready_busy", 32'(bus.ex_ready), 32'd0);
        chk("mem_addr", bus.mem_addr, alu);
        chk("mem_we", 32'(bus.mem_we), 32'(st));
        if (st) chk("mem_wdata", bus.mem_wdata, o2);
        if (reqs == d) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdat;
        end
        @(posedge clk);
      end
      chk("req_cycles", 32'(reqs), 32'(want_reqs));
    end else begin
      @(negedge clk);
      bus.ex_valid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    bus.ex_valid = 0; bus.aluResult = 0; bus.op2 = 0; bus.isLd = 0;
    bus.isSt = 0; bus.isWb = 0; bus.rd = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    #1;
    chk("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_ma_valid", 32'(bus.ma_valid), 32'd0);
    chk("rst_ma_result", bus.ma_result, 32'd0);
    chk("rst_ma_rd", 32'(bus.ma_rd), 32'd0);
    chk("rst_ma_isWb", 32'(bus.ma_isWb), 32'd0);
    chk("rst_ma_err", 32'(bus.ma_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(0, 0, 1, 32'h0000_1234, 32'h0, 4'd5, 0);          // pass-through
    issue(1, 0, 1, 32'h0000_0100, 32'h0, 4'd3, 3);          // load, 3 req cycles
    issue(0, 1, 1, 32'h0000_0200, 32'hA5A5_A5A5, 4'd7, 1);  // zero-wait store
    issue(1, 0, 1, 32'h0000_0102, 32'h0, 4'd2, 0);          // misaligned
    issue(1, 1, 1, 32'h0000_0300, 32'h0, 4'd4, 0);          // ld+st illegal
    issue(1, 0, 1, 32'h0000_0400, 32'h0, 4'd6, 100);        // timeout
    issue(1, 0, 1, 32'h0000_0404, 32'h0, 4'd8, WMAX + 1);   // ack on last cycle
    issue(0, 0, 0, 32'hFFFF_FFFF, 32'h0, 4'd15, 0);         // back-to-back pair
    issue(0, 0, 1, 32'h0000_0000, 32'h0, 4'd1, 0);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      a = $urandom;
      if (kind < 8) a[1:0] = 2'b00;
      case (kind % 4)
        0:       issue(0, 0, 1'($urandom), a, $urandom, 4'($urandom), 0);
        1:       issue(1, 0, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(1, 7));
        2:       issue(0, 1, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(1, 7));
        default: issue(1, 1'(kind == 3), 1, a, $urandom, 4'($urandom), $urandom_range(1, 3));
      endcase
    end

    // Reset in the middle of a load: nothing may come out for it.
    bus.ex_valid = 1; bus.aluResult = 32'h0000_0800; bus.isLd = 1; bus.isSt = 0;
    bus.isWb = 1; bus.rd = 4'd9;
    @(posedge clk);
    @(negedge clk);
    bus.ex_valid = 0;
    chk("mem_req_before_rst", 32'(bus.mem_req), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mid_ma_valid", 32'(bus.ma_valid), 32'd0);
    chk("rst_mid_ex_ready", 32'(bus.ex_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("post_rst_ex_ready", 32'(bus.ex_ready), 32'd1);
    issue(0, 0, 1, 32'h0000_0ABC, 32'h0, 4'd11, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
